// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and the default bus address
// used by both the master and the target.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_RX,
        ST_RX_ACK
    } state_e;

    localparam logic [6:0] I2C_SLAVE_ADDR = 7'b1100101;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Registers the bus lines and flags scl edges and START/STOP conditions
// relative to the previous sys_clk sample.
module i2c_bus_monitor (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic scl,
    input  logic sda,
    output logic rise,
    output logic fall,
    output logic start,
    output logic stop
);

    logic scl_q, scl_d;
    logic sda_q, sda_d;

    always_comb begin
        scl_d = scl;
        sda_d = sda;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_d;
            sda_q <= sda_d;
        end
    end

    // sda moving while scl rises is data, so START/STOP need scl high twice
    always_comb begin
        rise  = !scl_q & scl;
        fall  = scl_q & !scl;
        start = scl_q & scl & sda_q & !sda;
        stop  = scl_q & scl & !sda_q & sda;
    end

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: address match with ACK, read bytes from tx_data and
// write bytes delivered on rx_data with a one-cycle valid strobe.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = I2C_SLAVE_ADDR,
    parameter bit         ACK_EN     = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       scl,
    input  logic       sda,
    output logic       sda_slave,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       rw,
    output logic       busy
);

    localparam logic ACK_LVL = ACK_EN ? 1'b0 : 1'b1;

    logic rise, fall, start, stop;

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] cnt_q, cnt_d;
    logic       phase_q, phase_d;
    logic       sda_slave_q, sda_slave_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       addr_match_q, addr_match_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;

    i2c_bus_monitor u_mon (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .scl     (scl),
        .sda     (sda),
        .rise    (rise),
        .fall    (fall),
        .start   (start),
        .stop    (stop)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        sda_slave_d  = sda_slave_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        tx_req_d     = 1'b0;
        addr_match_d = 1'b0;
        rw_d         = rw_q;
        busy_d       = busy_q;
        if (start) begin
            state_d     = ST_ADDR;
            cnt_d       = 4'd0;
            phase_d     = 1'b0;
            sda_slave_d = 1'b1;
            busy_d      = 1'b0;
        end else if (stop) begin
            state_d     = ST_IDLE;
            cnt_d       = 4'd0;
            phase_d     = 1'b0;
            sda_slave_d = 1'b1;
            busy_d      = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: begin
                    if (rise) begin
                        shift_d = {shift_q[6:0], sda};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (shift_q[6:0] == SLAVE_ADDR) begin
                                addr_match_d = 1'b1;
                                rw_d         = sda;
                                busy_d       = 1'b1;
                                phase_d      = 1'b0;
                                state_d      = ST_ADDR_ACK;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (fall && !phase_q) begin
                        sda_slave_d = ACK_LVL;
                        phase_d     = 1'b1;
                    end else if (fall) begin
                        phase_d = 1'b0;
                        cnt_d   = 4'd0;
                        if (rw_q) begin
                            shift_d     = tx_data;
                            tx_req_d    = 1'b1;
                            sda_slave_d = tx_data[7];
                            state_d     = ST_TX;
                        end else begin
                            sda_slave_d = 1'b1;
                            state_d     = ST_RX;
                        end
                    end
                end
                ST_TX: begin
                    if (fall) begin
                        if (cnt_q == 4'd7) begin
                            sda_slave_d = 1'b1;
                            cnt_d       = 4'd0;
                            phase_d     = 1'b0;
                            state_d     = ST_TX_ACK;
                        end else begin
                            shift_d     = {shift_q[6:0], 1'b0};
                            sda_slave_d = shift_q[6];
                            cnt_d       = cnt_q + 4'd1;
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (rise && sda) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (rise) begin
                        phase_d = 1'b1;
                    end else if (fall && phase_q) begin
                        shift_d     = tx_data;
                        tx_req_d    = 1'b1;
                        sda_slave_d = tx_data[7];
                        cnt_d       = 4'd0;
                        phase_d     = 1'b0;
                        state_d     = ST_TX;
                    end
                end
                ST_RX: begin
                    if (rise) begin
                        shift_d = {shift_q[6:0], sda};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rx_data_d  = {shift_q[6:0], sda};
                            rx_valid_d = 1'b1;
                            cnt_d      = 4'd0;
                            phase_d    = 1'b0;
                            state_d    = ST_RX_ACK;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (fall && !phase_q) begin
                        sda_slave_d = ACK_LVL;
                        phase_d     = 1'b1;
                    end else if (fall) begin
                        sda_slave_d = 1'b1;
                        phase_d     = 1'b0;
                        cnt_d       = 4'd0;
                        state_d     = ST_RX;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= 8'h00;
            cnt_q        <= 4'd0;
            phase_q      <= 1'b0;
            sda_slave_q  <= 1'b1;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            tx_req_q     <= 1'b0;
            addr_match_q <= 1'b0;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            sda_slave_q  <= sda_slave_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            tx_req_q     <= tx_req_d;
            addr_match_q <= addr_match_d;
            rw_q         <= rw_d;
            busy_q       <= busy_d;
        end
    end

    assign sda_slave  = sda_slave_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign tx_req     = tx_req_q;
    assign addr_match = addr_match_q;
    assign rw         = rw_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: acts as the I2C master and
// checks an ACK_EN=1 target and an ACK_EN=0 target on the same bus.
module tb_i2c_slave_responder;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda = 1'b1;
    logic [7:0] tx_data = 8'h00;

    logic       sda_slave, tx_req, rx_valid, addr_match, rw, busy;
    logic [7:0] rx_data;
    logic       sda_slave2, tx_req2, rx_valid2, addr_match2, rw2, busy2;
    logic [7:0] rx_data2;

    int checks = 0;
    int failures = 0;
    int am_cnt = 0, txr_cnt = 0, rxv_cnt = 0, low_cnt = 0;
    int am2_cnt = 0, rxv2_cnt = 0;

    i2c_slave_responder #(.ACK_EN(1'b1)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .scl        (scl),
        .sda        (sda),
        .sda_slave  (sda_slave),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .addr_match (addr_match),
        .rw         (rw),
        .busy       (busy)
    );

    i2c_slave_responder #(.ACK_EN(1'b0)) dut_noack (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .scl        (scl),
        .sda        (sda),
        .sda_slave  (sda_slave2),
        .tx_data    (tx_data),
        .tx_req     (tx_req2),
        .rx_data    (rx_data2),
        .rx_valid   (rx_valid2),
        .addr_match (addr_match2),
        .rw         (rw2),
        .busy       (busy2)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (addr_match)  am_cnt++;
        if (tx_req)      txr_cnt++;
        if (rx_valid)    rxv_cnt++;
        if (!sda_slave)  low_cnt++;
        if (addr_match2) am2_cnt++;
        if (rx_valid2)   rxv2_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_bit(input logic b, output logic s1, output logic s2);
        sda = b;
        tick(2);
        scl = 1'b1;
        tick(1);
        s1 = sda_slave;
        s2 = sda_slave2;
        tick(1);
        scl = 1'b0;
        tick(2);
    endtask

    task automatic xfer(input logic [7:0] b, input logic ack,
                        output logic [7:0] seen1, output logic [7:0] seen2,
                        output logic a1, output logic a2);
        logic s1, s2;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(b[i], s1, s2);
            seen1[i] = s1;
            seen2[i] = s2;
        end
        clk_bit(ack, a1, a2);
    endtask

    task automatic do_start();
        sda = 1'b1;
        tick(2);
        scl = 1'b1;
        tick(2);
        sda = 1'b0;
        tick(2);
        scl = 1'b0;
        tick(2);
    endtask

    task automatic do_stop();
        sda = 1'b0;
        tick(2);
        scl = 1'b1;
        tick(2);
        sda = 1'b1;
        tick(4);
    endtask

    initial begin
        logic [7:0] s1, s2;
        logic       a1, a2, b1, b2;
        int         am0, rxv0, low0, am20;

        // reset
        tick(3);
        sys_rst = 1'b0;
        tick(3);
        chk("rst_sda_slave", sda_slave, 1'b1);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_flags", {rx_valid, tx_req, addr_match, rw, busy}, 5'b0);
        chk("rst_pulses", am_cnt + txr_cnt + rxv_cnt + low_cnt, 0);

        // read 0xA5 (master ACK) then 0x3C (master NACK)
        tx_data = 8'hA5;
        do_start();
        xfer(8'hCB, 1'b1, s1, s2, a1, a2);
        chk("rd_addr_ack", a1, 1'b0);
        chk("rd_addr_match", am_cnt, 1);
        chk("rd_rw", rw, 1'b1);
        chk("rd_busy", busy, 1'b1);
        chk("rd_txreq1", txr_cnt, 1);
        tx_data = 8'h3C;
        xfer(8'hFF, 1'b0, s1, s2, a1, a2);
        chk("rd_byte1", s1, 8'hA5);
        chk("rd_mack_released", a1, 1'b1);
        xfer(8'hFF, 1'b1, s1, s2, a1, a2);
        chk("rd_byte2", s1, 8'h3C);
        chk("rd_txreq2", txr_cnt, 2);
        chk("rd_nack_busy", busy, 1'b0);
        chk("rd_nack_sda", sda_slave, 1'b1);
        do_stop();
        chk("rd_stop_sda", sda_slave, 1'b1);

        // write 0x5E
        rxv0 = rxv_cnt;
        am20 = am2_cnt;
        do_start();
        xfer(8'hCA, 1'b1, s1, s2, a1, a2);
        chk("wr_addr_ack", a1, 1'b0);
        chk("wr_addr_noack2", a2, 1'b1);
        chk("wr_am2", am2_cnt, am20 + 1);
        chk("wr_rw", rw, 1'b0);
        xfer(8'h5E, 1'b1, s1, s2, a1, a2);
        chk("wr_data_released", s1, 8'hFF);
        chk("wr_data_ack", a1, 1'b0);
        chk("wr_data_noack2", a2, 1'b1);
        chk("wr_rxvalid", rxv_cnt, rxv0 + 1);
        chk("wr_rx_data", rx_data, 8'h5E);
        chk("wr_rx_data2", rx_data2, 8'h5E);
        chk("wr_busy", busy, 1'b1);
        do_stop();
        chk("wr_stop_busy", busy, 1'b0);

        // wrong address 0x90, following byte ignored
        am0 = am_cnt;
        rxv0 = rxv_cnt;
        do_start();
        xfer(8'h90, 1'b1, s1, s2, a1, a2);
        chk("na_ack", a1, 1'b1);
        chk("na_match", am_cnt, am0);
        low0 = low_cnt;
        xfer(8'h00, 1'b1, s1, s2, a1, a2);
        chk("na_never_low", low_cnt, low0);
        chk("na_no_rx", rxv_cnt, rxv0);
        chk("na_busy", busy, 1'b0);
        do_stop();

        // write aborted after 4 bits by repeated START, then read 0x96
        rxv0 = rxv_cnt;
        am0 = am_cnt;
        do_start();
        xfer(8'hCA, 1'b1, s1, s2, a1, a2);
        chk("ab_addr_ack", a1, 1'b0);
        chk("ab_addr_noack2", a2, 1'b1);
        clk_bit(1'b1, b1, b2);
        clk_bit(1'b0, b1, b2);
        clk_bit(1'b1, b1, b2);
        clk_bit(1'b0, b1, b2);
        tx_data = 8'h96;
        do_start();
        xfer(8'hCB, 1'b1, s1, s2, a1, a2);
        chk("ab_rd_ack", a1, 1'b0);
        chk("ab_rd_noack2", a2, 1'b1);
        chk("ab_match", am_cnt, am0 + 2);
        xfer(8'hFF, 1'b1, s1, s2, a1, a2);
        chk("ab_byte", s1, 8'h96);
        chk("ab_byte2", s2, 8'h96);
        chk("ab_no_rx", rxv_cnt, rxv0);
        chk("ab_no_rx2", rxv2_cnt, 1);
        chk("ab_busy", busy, 1'b0);
        do_stop();

        // reset while driving a 0 data bit
        tx_data = 8'h00;
        do_start();
        xfer(8'hCB, 1'b1, s1, s2, a1, a2);
        chk("mr_driving", sda_slave, 1'b0);
        sys_rst = 1'b1;
        tick(1);
        chk("mr_release", sda_slave, 1'b1);
        chk("mr_busy", busy, 1'b0);
        sys_rst = 1'b0;
        scl = 1'b1;
        sda = 1'b1;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable I2C target (slave) that sits directly downstream of the team's `top` I2C master.
- Consumes the master's `scl`/`sda` and produces `sda_slave`.
- Detects START/STOP, matches a 7-bit address and ACKs it.
- Serves read bytes from a user-side `tx_data` port; delivers write bytes on `rx_data` with a valid strobe.
- Gives the master a realistic on-chip counterpart for simulation and on-FPGA loopback.

Parameters:
- SLAVE_ADDR, 7'b1100101, 7-bit address this target answers to.
- ACK_EN, 1, 1 = drive ACK after the address and each received byte; 0 = never pull `sda_slave` low in ACK slots (slots are still counted).

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- scl  input  1  bus clock from the master, synchronous to sys_clk.
- sda  input  1  bus data from the master.
- sda_slave  output  1  target data drive; 1 = released/high, 0 = pulled low.
- tx_data  input  8  byte to return on the next read byte; sampled when the byte is loaded.
- tx_req  output  1  one-cycle pulse when tx_data is loaded into the shifter; user must present the next byte before the next load.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- addr_match  output  1  one-cycle pulse when the address byte matches SLAVE_ADDR.
- rw  output  1  R/W bit of the current transaction (1 = read); held until the next address byte.
- busy  output  1  high from address match until STOP, NACK, or the next START.

Behaviour:
- Reset values: sda_slave=1, rx_data=0, rx_valid=0, tx_req=0, addr_match=0, rw=0, busy=0. State goes to IDLE; shift register and bit counter clear.
- Bus registering: scl_q and sda_q hold the previous cycle's scl/sda; reset value 1.
- Edge detection:
  - rise = !scl_q & scl; fall = scl_q & !scl.
  - START = scl_q & scl & sda_q & !sda.
  - STOP = scl_q & scl & !sda_q & sda.
  - sda changing in the same cycle that scl rises is a data bit, never START/STOP.
- Data sampling and driving:
  - Data bits are sampled at rise using the current sda.
  - sda_slave changes only in the cycle after fall is detected (registered). It is therefore stable before the next scl high phase.
- Priority, from highest: sys_rst, then START (any state goes to ADDR, counter=0, sda_slave=1), then STOP (any state goes to IDLE, sda_slave=1), then the state logic.
- IDLE: ignore everything except START.
- ADDR:
  - Shift 8 bits MSB first on rise.
  - After the 8th rise, compare bits[7:1] with SLAVE_ADDR.
  - Mismatch: go to IDLE; never drive.
  - Match: pulse addr_match, set rw=bit0, set busy=1, go to ADDR_ACK.
- ADDR_ACK:
  - At the next fall, sda_slave=!ACK_EN.
  - At the following fall: if rw=1, enter TX and load the byte; else release sda_slave=1 and enter RX.
- TX:
  - Load happens at the fall that ends the ACK slot: shifter<=tx_data, tx_req pulses, sda_slave=tx_data[7].
  - Each subsequent fall shifts out the next bit.
  - After 8 bits, at the next fall, release sda_slave=1 and go to TX_ACK.
- TX_ACK:
  - Sample sda at rise.
  - 0 (ACK): at the next fall, load the next byte as above and return to TX.
  - 1 (NACK): go to IDLE, busy=0, sda_slave stays 1.
- RX:
  - Shift on rise.
  - On the cycle after the 8th rise: rx_data<=byte, rx_valid=1 for one cycle, go to RX_ACK.
- RX_ACK: at fall, sda_slave=!ACK_EN; at the next fall, release to 1 and return to RX (counter=0).
- Bit counter: 4 bits, wraps 7 to 0 per byte.
- Clock stretching: none.
- Boundary cases:
  - Repeated START mid-byte aborts the byte; no rx_valid.
  - STOP mid-byte drops the partial byte.
  - sys_rst mid-transfer releases sda_slave in the next cycle.

Decomposition:
- Shared package `i2c_pkg`:
  - state encodings (IDLE, ADDR, ADDR_ACK, TX, TX_ACK, RX, RX_ACK);
  - default SLAVE_ADDR constant 7'b1100101, shared with the master.
- One sub-module, `i2c_bus_monitor`: registers scl/sda and outputs rise, fall, start, stop.
- Shifter, counter and FSM stay in the top.

Test Plan:
- Reset held 3 cycles, then released with scl=sda=1 -> all outputs at reset values; IDLE; no pulses.
- START, address 0xCB (read), master ACKs, tx_data=0xA5 -> addr_match pulse; rw=1; sda_slave=0 during the ACK slot; bits 1,0,1,0,0,1,0,1 observed on consecutive scl-high phases; one tx_req.
- Read with master ACK then NACK, tx_data=0xA5 then 0x3C -> 0xA5 then 0x3C shifted out; two tx_req pulses; after NACK, busy=0 and sda_slave=1 until STOP.
- START, address 0xCA (write), byte 0x5E, STOP -> rx_valid single pulse with rx_data=0x5E; sda_slave=0 in both ACK slots; busy falls at STOP.
- START, address 0x90 -> no addr_match; sda_slave=1 throughout; following bytes ignored until the next START.
- Write byte interrupted after 4 bits by repeated START, then address 0xCB -> no rx_valid; new read transaction proceeds normally. Repeat with ACK_EN=0 -> sda_slave never 0 during ACK slots.
